// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: FSM encoding and index-width helper.
package csa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Chunk-index width; a single-chunk build still needs a 1-bit counter.
  function automatic int idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CW-bit slice adder with carry in/out, reused by the resolver each RUN cycle.
module csa_chunk_add #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve.sv
// Resolves a carry-save (sum, carry) pair to binary, one CW-bit chunk per cycle,
// behind valid/ready handshakes on both sides.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_s,
  input  logic [DW-1:0] in_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] out_sum,
  output logic          busy
);

  localparam int NCHUNK = DW / CW;
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  logic [1:0]                   state;
  logic [NCHUNK-1:0][CW-1:0]    a_q, b_q, lo_q;
  logic [1:0]                   hi_q;
  logic                         ctop_q, carry_q;
  logic [IW-1:0]                idx;

  logic [CW-1:0] a_sl, b_sl, ch_sum;
  logic          ch_cout;

  // Explicit compare-select keeps the slice mux in range for any NCHUNK.
  always_comb begin
    a_sl = a_q[0];
    b_sl = b_q[0];
    for (int k = 1; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        a_sl = a_q[k];
        b_sl = b_q[k];
      end
    end
  end

  csa_chunk_add #(.CW(CW)) u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ctop_q  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_q     <= in_s;
          b_q     <= {in_c[DW-2:0], 1'b0};
          ctop_q  <= in_c[DW-1];
          carry_q <= 1'b0;
          idx     <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          for (int k = 0; k < NCHUNK; k++)
            if (idx == IW'(k)) lo_q[k] <= ch_sum;
          carry_q <= ch_cout;
          idx     <= idx + 1'b1;
          // The carry shifted out of in_c's MSB joins the final carry in the top two bits.
          if (idx == LAST) begin
            hi_q  <= {1'b0, ch_cout} + {1'b0, ctop_q};
            state <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign out_sum   = {hi_q, lo_q};

endmodule
